imem_port_arbiter: RTL and testbench

//  Shares the single-port instruction memory between CPU instruction fetch and a program loader.

---
 rtl/imem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_imem_port_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-port instruction memory between fetch and the program loader.
// Latency: grant is combinational, response is a 1-cycle rvalid pulse two cycles after grant; no backpressure.
// Optional IMEM_ARB_FAIR_EN: round-robin tie-break in RUN instead of fixed loader priority.
module imem_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [31:0]       f_pc,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_instr,
    output logic              f_err,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    input  logic              l_done,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              f_addr_err;
    logic [ADDR_W-1:0] f_word;

    // Pipeline stage between grant and response (memory read in flight)
    logic s1_vld;
    logic s1_loader;
    logic s1_err;
    logic s1_we;

    // A misaligned or out-of-range PC is still granted but never reaches memory
    assign f_addr_err = (f_pc[1:0] != 2'b00) || (f_pc[31:ADDR_W+2] != '0);
    assign f_word     = f_pc[ADDR_W+1:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == BOOT && l_done) begin
            state_nxt = RUN;
        end
    end

`ifdef IMEM_ARB_FAIR_EN
    logic last_loader;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_loader <= 1'b0;
        end else if (state == RUN && (l_gnt || f_gnt)) begin
            last_loader <= l_gnt;
        end
    end
`endif

    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (!rst) begin
            case (state)
                BOOT: l_gnt = l_req;
                RUN: begin
                    if (l_req && f_req) begin
`ifdef IMEM_ARB_FAIR_EN
                        f_gnt = last_loader;
                        l_gnt = !last_loader;
`else
                        l_gnt = 1'b1;
`endif
                    end else begin
                        l_gnt = l_req;
                        f_gnt = f_req;
                    end
                end
                default: begin
                    f_gnt = 1'b0;
                    l_gnt = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (l_gnt) begin
            mem_en    = 1'b1;
            mem_we    = l_we;
            mem_addr  = l_addr;
            mem_wdata = l_wdata;
        end else if (f_gnt && !f_addr_err) begin
            mem_en    = 1'b1;
            mem_addr  = f_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld    <= 1'b0;
            s1_loader <= 1'b0;
            s1_err    <= 1'b0;
            s1_we     <= 1'b0;
        end else begin
            s1_vld    <= l_gnt || f_gnt;
            s1_loader <= l_gnt;
            s1_err    <= f_gnt && f_addr_err;
            s1_we     <= l_gnt && l_we;
        end
    end

    // Responses are recomputed every cycle, so each rvalid lasts exactly one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_rvalid <= 1'b0;
            f_err    <= 1'b0;
            f_instr  <= '0;
            l_rvalid <= 1'b0;
            l_rdata  <= '0;
        end else begin
            f_rvalid <= s1_vld && !s1_loader;
            f_err    <= s1_vld && !s1_loader && s1_err;
            f_instr  <= (s1_vld && !s1_loader && !s1_err) ? mem_rdata : '0;
            l_rvalid <= s1_vld && s1_loader;
            l_rdata  <= (s1_vld && s1_loader && !s1_we) ? mem_rdata : '0;
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural synchronous-read memory.
module tb_imem_port_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              f_req;
    logic [31:0]       f_pc;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_instr;
    logic              f_err;
    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_done;
    logic              l_gnt;
    logic              l_rvalid;
    logic [DATA_W-1:0] l_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] mem [256];
    logic [DATA_W-1:0] words [3];

    int vectors;
    int miscompares;

    imem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_pc(f_pc), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .f_instr(f_instr), .f_err(f_err),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_done(l_done), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; f_req = 1'b1; f_pc = 32'h0; l_req = 1'b1; l_we = 1'b0;
        l_addr = '0; l_wdata = '0; l_done = 1'b0;
        #2;
        vectors++; if (f_gnt !== 1'b0) begin miscompares++; $display("FAIL rst_f_gnt: got %b want 0", f_gnt); end
        vectors++; if (l_gnt !== 1'b0) begin miscompares++; $display("FAIL rst_l_gnt: got %b want 0", l_gnt); end
        vectors++; if (mem_en !== 1'b0) begin miscompares++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
        vectors++; if (f_rvalid !== 1'b0) begin miscompares++; $display("FAIL rst_f_rvalid: got %b want 0", f_rvalid); end
        vectors++; if (l_rvalid !== 1'b0) begin miscompares++; $display("FAIL rst_l_rvalid: got %b want 0", l_rvalid); end
        @(posedge clk); #1;
        rst = 1'b0; l_req = 1'b0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            f_req = 1'b1; f_pc = 32'h0;
            #1;
            vectors++; if (f_gnt !== 1'b0) begin miscompares++; $display("FAIL boot_f_gnt c%0d: got %b want 0", c, f_gnt); end
            vectors++; if (mem_en !== 1'b0) begin miscompares++; $display("FAIL boot_mem_en c%0d: got %b want 0", c, mem_en); end
        end
    endtask

    task automatic test_load();
        logic exp_lv;
        for (int c = 0; c < 6; c++) begin
            cyc();
            f_req = 1'b0;
            l_req = (c < 3); l_we = 1'b1; l_addr = 8'(c);
            l_wdata = (c < 3) ? words[c] : '0;
            l_done = (c == 2);
            #1;
            if (c < 3) begin
                vectors++; if (l_gnt !== 1'b1) begin miscompares++; $display("FAIL load_l_gnt c%0d: got %b want 1", c, l_gnt); end
                vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL load_mem_we c%0d: got %b want 1", c, mem_we); end
                vectors++; if (mem_addr !== 8'(c)) begin miscompares++; $display("FAIL load_mem_addr c%0d: got %h want %h", c, mem_addr, 8'(c)); end
                vectors++; if (mem_wdata !== words[c]) begin miscompares++; $display("FAIL load_mem_wdata c%0d: got %h want %h", c, mem_wdata, words[c]); end
            end
            exp_lv = (c >= 2 && c < 5);
            vectors++; if (l_rvalid !== exp_lv) begin miscompares++; $display("FAIL load_l_rvalid c%0d: got %b want %b", c, l_rvalid, exp_lv); end
            if (exp_lv) begin
                vectors++; if (l_rdata !== 32'h0) begin miscompares++; $display("FAIL load_ack_rdata c%0d: got %h want 0", c, l_rdata); end
            end
        end
        l_req = 1'b0; l_done = 1'b0;
    endtask

    task automatic test_fetch();
        logic exp_fv;
        for (int c = 0; c < 6; c++) begin
            cyc();
            f_req = (c < 3); f_pc = 32'(c * 4); l_req = 1'b0;
            #1;
            if (c < 3) begin
                vectors++; if (f_gnt !== 1'b1) begin miscompares++; $display("FAIL fetch_f_gnt c%0d: got %b want 1", c, f_gnt); end
                vectors++; if (mem_en !== 1'b1) begin miscompares++; $display("FAIL fetch_mem_en c%0d: got %b want 1", c, mem_en); end
                vectors++; if (mem_addr !== 8'(c)) begin miscompares++; $display("FAIL fetch_mem_addr c%0d: got %h want %h", c, mem_addr, 8'(c)); end
            end
            exp_fv = (c >= 2 && c < 5);
            vectors++; if (f_rvalid !== exp_fv) begin miscompares++; $display("FAIL fetch_f_rvalid c%0d: got %b want %b", c, f_rvalid, exp_fv); end
            if (exp_fv) begin
                vectors++; if (f_instr !== words[c-2]) begin miscompares++; $display("FAIL fetch_f_instr c%0d: got %h want %h", c, f_instr, words[c-2]); end
                vectors++; if (f_err !== 1'b0) begin miscompares++; $display("FAIL fetch_f_err c%0d: got %b want 0", c, f_err); end
            end
        end
        f_req = 1'b0;
    endtask

    task automatic test_priority();
        logic exp_l;
        // Fresh reset so the fair-mode last winner is fetch
        cyc(); rst = 1'b1; f_req = 1'b0; l_req = 1'b0;
        cyc(); rst = 1'b0;
        cyc(); l_done = 1'b1;
        cyc(); l_done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cyc();
            f_req = 1'b1; f_pc = 32'h0; l_req = 1'b1; l_we = 1'b0; l_addr = 8'h0;
            #1;
`ifdef IMEM_ARB_FAIR_EN
            exp_l = ((c % 2) == 0);
`else
            exp_l = 1'b1;
`endif
            vectors++; if (l_gnt !== exp_l) begin miscompares++; $display("FAIL tie_l_gnt c%0d: got %b want %b", c, l_gnt, exp_l); end
            vectors++; if (f_gnt !== !exp_l) begin miscompares++; $display("FAIL tie_f_gnt c%0d: got %b want %b", c, f_gnt, !exp_l); end
        end
        cyc(); f_req = 1'b0; l_req = 1'b0;
        cyc(); cyc(); cyc();
    endtask

    task automatic test_misalign();
        cyc(); f_req = 1'b1; f_pc = 32'h6;
        #1;
        vectors++; if (f_gnt !== 1'b1) begin miscompares++; $display("FAIL mis_f_gnt: got %b want 1", f_gnt); end
        vectors++; if (mem_en !== 1'b0) begin miscompares++; $display("FAIL mis_mem_en: got %b want 0", mem_en); end
        cyc(); f_req = 1'b0;
        vectors++; if (f_rvalid !== 1'b0) begin miscompares++; $display("FAIL mis_early_rvalid: got %b want 0", f_rvalid); end
        cyc();
        vectors++; if (f_rvalid !== 1'b1) begin miscompares++; $display("FAIL mis_f_rvalid: got %b want 1", f_rvalid); end
        vectors++; if (f_err !== 1'b1) begin miscompares++; $display("FAIL mis_f_err: got %b want 1", f_err); end
        vectors++; if (f_instr !== 32'h0) begin miscompares++; $display("FAIL mis_f_instr: got %h want 0", f_instr); end
        cyc();
        vectors++; if (f_rvalid !== 1'b0) begin miscompares++; $display("FAIL mis_pulse: got %b want 0", f_rvalid); end
    endtask

    task automatic test_range_rw();
        for (int c = 0; c < 5; c++) begin
            cyc();
            f_req = (c == 0); f_pc = 32'h400;
            l_req = (c == 1 || c == 2); l_we = (c == 1); l_addr = 8'h3; l_wdata = 32'hDEADBEEF;
            #1;
            case (c)
                0: begin
                    vectors++; if (f_gnt !== 1'b1) begin miscompares++; $display("FAIL rng_f_gnt: got %b want 1", f_gnt); end
                    vectors++; if (mem_en !== 1'b0) begin miscompares++; $display("FAIL rng_mem_en: got %b want 0", mem_en); end
                end
                1: begin
                    vectors++; if (l_gnt !== 1'b1) begin miscompares++; $display("FAIL wr_l_gnt: got %b want 1", l_gnt); end
                    vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL wr_mem_we: got %b want 1", mem_we); end
                end
                2: begin
                    vectors++; if (mem_we !== 1'b0 || mem_en !== 1'b1) begin miscompares++; $display("FAIL rd_mem_ctl: got en=%b we=%b want en=1 we=0", mem_en, mem_we); end
                    vectors++; if (f_rvalid !== 1'b1) begin miscompares++; $display("FAIL rng_f_rvalid: got %b want 1", f_rvalid); end
                    vectors++; if (f_err !== 1'b1) begin miscompares++; $display("FAIL rng_f_err: got %b want 1", f_err); end
                    vectors++; if (f_instr !== 32'h0) begin miscompares++; $display("FAIL rng_f_instr: got %h want 0", f_instr); end
                end
                3: begin
                    vectors++; if (l_rvalid !== 1'b1) begin miscompares++; $display("FAIL wr_ack_rvalid: got %b want 1", l_rvalid); end
                    vectors++; if (l_rdata !== 32'h0) begin miscompares++; $display("FAIL wr_ack_rdata: got %h want 0", l_rdata); end
                end
                default: begin
                    vectors++; if (l_rvalid !== 1'b1) begin miscompares++; $display("FAIL rd_rvalid: got %b want 1", l_rvalid); end
                    vectors++; if (l_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_rdata: got %h want deadbeef", l_rdata); end
                end
            endcase
        end
        cyc(); f_req = 1'b0; l_req = 1'b0; l_we = 1'b0;
        cyc(); cyc();
    endtask

    task automatic test_reset_flush();
        cyc(); f_req = 1'b1; f_pc = 32'h8;
        #1;
        vectors++; if (f_gnt !== 1'b1) begin miscompares++; $display("FAIL flush_f_gnt: got %b want 1", f_gnt); end
        cyc(); rst = 1'b1;
        #1;
        vectors++; if (f_gnt !== 1'b0 || mem_en !== 1'b0) begin miscompares++; $display("FAIL flush_comb: got gnt=%b en=%b want 0 0", f_gnt, mem_en); end
        cyc();
        vectors++; if (f_rvalid !== 1'b0) begin miscompares++; $display("FAIL flush_f_rvalid: got %b want 0", f_rvalid); end
        rst = 1'b0;
        #1;
        vectors++; if (f_gnt !== 1'b0) begin miscompares++; $display("FAIL flush_boot_gnt: got %b want 0", f_gnt); end
        cyc();
        vectors++; if (f_rvalid !== 1'b0) begin miscompares++; $display("FAIL flush_late_rvalid: got %b want 0", f_rvalid); end
        vectors++; if (f_gnt !== 1'b0) begin miscompares++; $display("FAIL flush_boot_gnt2: got %b want 0", f_gnt); end
        f_req = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        words[0] = 32'h8C010004;
        words[1] = 32'h8C0C000C;
        words[2] = 32'h8C030014;
        test_reset();
        test_load();
        test_fetch();
        test_priority();
        test_misalign();
        test_range_rw();
        test_reset_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
